// File: rtl/mem_access_unit.sv
// Purpose: load/store front end for a word-wide synchronous-read data memory (byte/half/word, big-endian).
// Latency: SW completes in 1 cycle, loads and SB/SH read-modify-write complete in 2 cycles.
// Backpressure: Busy is high outside IDLE and requests seen then are dropped, not queued.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MemReq,
  input  logic              MemWe,
  input  logic [1:0]        MemSize,
  input  logic              MemUnsigned,
  input  logic [ADDR_W-1:0] MemAddr,
  input  logic [31:0]       MemWrData,
  output logic              Busy,
  output logic              Done,
  output logic [31:0]       LoadData,
  output logic              AddrErr,
  output logic [31:0]       DmemAddr,
  output logic              DmemWrite,
  output logic [31:0]       DmemWrData,
  input  logic [31:0]       DmemRdData
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MERGE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [15:0]       r_wrdata;
  logic              r_done;
  logic              r_addr_err;
  logic [31:0]       r_load_data;

  logic              w_err;
  logic              w_accept;
  logic              w_is_sw;
  logic [ADDR_W-1:0] w_idx;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_ext;
  logic [31:0]       w_merged;

  // Illegal size, or an address not aligned to the access size
  assign w_err    = (MemSize == 2'b11) ||
                    ((MemSize == SZ_WORD) && (MemAddr[1:0] != 2'b00)) ||
                    ((MemSize == SZ_HALF) && MemAddr[0]);
  assign w_accept = (r_state == S_IDLE) && MemReq && !w_err;
  assign w_is_sw  = MemWe && (MemSize == SZ_WORD);

  assign Busy     = (r_state != S_IDLE);
  assign Done     = r_done;
  assign AddrErr  = r_addr_err;
  assign LoadData = r_load_data;
  assign DmemAddr = 32'(w_idx);

  // Lane select and sign/zero extension of the read word (offset 0 is the MSB lane)
  always_comb begin
    w_byte = DmemRdData[7:0];
    case (r_addr[1:0])
      2'd0:    w_byte = DmemRdData[31:24];
      2'd1:    w_byte = DmemRdData[23:16];
      2'd2:    w_byte = DmemRdData[15:8];
      default: w_byte = DmemRdData[7:0];
    endcase
    w_half = r_addr[1] ? DmemRdData[15:0] : DmemRdData[31:16];
    w_load_ext = DmemRdData;
    if (r_size == SZ_BYTE) begin
      w_load_ext = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
    end else if (r_size == SZ_HALF) begin
      w_load_ext = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
    end
  end

  // Overlay the captured store data onto the addressed lane, other lanes pass through
  always_comb begin
    w_merged = DmemRdData;
    if (r_size == SZ_BYTE) begin
      case (r_addr[1:0])
        2'd0:    w_merged[31:24] = r_wrdata[7:0];
        2'd1:    w_merged[23:16] = r_wrdata[7:0];
        2'd2:    w_merged[15:8]  = r_wrdata[7:0];
        default: w_merged[7:0]   = r_wrdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merged[15:0] = r_wrdata;
    end else begin
      w_merged[31:16] = r_wrdata;
    end
  end

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and memory-side outputs; IDLE passes the request straight through
  always_comb begin
    w_next     = r_state;
    w_idx      = r_addr >> 2;
    DmemWrite  = 1'b0;
    DmemWrData = w_merged;
    case (r_state)
      S_IDLE: begin
        w_idx      = MemAddr >> 2;
        DmemWrData = MemWrData;
        DmemWrite  = w_accept && w_is_sw;
        if (w_accept && !w_is_sw) w_next = MemWe ? S_MERGE : S_LOAD;
      end
      S_LOAD:  w_next = S_IDLE;
      S_MERGE: begin
        // Reset kills the write immediately so no partial word lands in memory
        DmemWrite = !Reset;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, load result register and the Done/AddrErr pulses
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_addr      <= '0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_wrdata    <= 16'd0;
      r_done      <= 1'b0;
      r_addr_err  <= 1'b0;
      r_load_data <= 32'd0;
    end else begin
      r_done     <= 1'b0;
      r_addr_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (MemReq && w_err) begin
            r_addr_err <= 1'b1;
          end else if (w_accept) begin
            r_addr     <= MemAddr;
            r_size     <= MemSize;
            r_unsigned <= MemUnsigned;
            r_wrdata   <= MemWrData[15:0];
            if (w_is_sw) r_done <= 1'b1;
          end
        end
        S_LOAD: begin
          r_load_data <= w_load_ext;
          r_done      <= 1'b1;
        end
        S_MERGE: r_done <= 1'b1;
        default: r_done <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end sitting directly upstream of the word-wide, synchronous-read data memory in the pipelined MIPS MEM stage. It:
- converts byte addresses from the pipeline into word indices;
- performs byte and halfword loads with sign/zero extension;
- implements byte and halfword stores as a two-cycle read-modify-write, since the memory only writes whole words;
- signals busy/done to the pipeline and flags misaligned accesses.

## Interface
Parameters:
- ADDR_W, 32, byte-address width from the pipeline.

Ports:
- Clk  input  1  rising-edge clock shared with the data memory.
- Reset  input  1  asynchronous, active-high reset.
- MemReq  input  1  request strobe; sampled only in IDLE.
- MemWe  input  1  1 = store, 0 = load.
- MemSize  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- MemUnsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- MemAddr  input  ADDR_W  byte address.
- MemWrData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- Busy  output  1  high whenever state is not IDLE; requests are ignored while high.
- Done  output  1  registered one-cycle pulse on completion of any accepted access.
- LoadData  output  32  registered, extended load result; valid while Done is high for a load, held otherwise.
- AddrErr  output  1  registered one-cycle pulse on a misaligned or illegal request.
- DmemAddr  output  32  word index = MemAddr >> 2 (captured address outside IDLE).
- DmemWrite  output  1  memory write enable.
- DmemWrData  output  32  word to write.
- DmemRdData  input  32  memory read data, registered one cycle after DmemAddr is driven.

## Operation
- Byte order is big-endian. Offset 0 is [31:24], offset 3 is [7:0]. Half offset 0 is [31:16], offset 2 is [15:0].
- Alignment rules:
  - Word access requires MemAddr[1:0] = 00.
  - Halfword access requires MemAddr[0] = 0.
  - MemSize = 11 is always an error.
  - An error pulses AddrErr in the next cycle. No Done, DmemWrite stays 0, state stays IDLE.
- States: IDLE, LOAD, MERGE.
- IDLE:
  - DmemAddr, DmemWrite and DmemWrData are combinational from the inputs.
  - Address, size, unsigned flag and store data are captured on acceptance.
  - SW → DmemWrite = 1 with DmemWrData = MemWrData this cycle, state stays IDLE, Done next cycle.
  - Load → drive DmemAddr, go to LOAD.
  - SB/SH → drive DmemAddr as a read, go to MERGE.
  - No request → DmemWrite = 0.
- LOAD:
  - Select the byte/half/word from DmemRdData using the captured offset, then extend it.
  - Register the result into LoadData and assert Done next cycle.
  - Return to IDLE.
- MERGE:
  - Replace the addressed lane of DmemRdData with captured store data; other lanes are unchanged.
  - Drive DmemWrite = 1, DmemWrData = merged word, DmemAddr = captured word index.
  - Done next cycle; return to IDLE.
- Reset (asynchronous): state IDLE, Done = 0, AddrErr = 0, LoadData = 0, captured registers = 0. DmemWrite = 0 unless MemReq is an aligned SW in that same cycle.

## Timing
- Request accepted in cycle T (IDLE, MemReq = 1):
  - SW: memory write at end of T; Done in T+1; Busy never asserted.
  - Load: Busy in T+1; LoadData/Done in T+2.
  - SB/SH: read at end of T; merged write at end of T+1; Busy in T+1; Done in T+2.
  - AddrErr: pulse in T+1.
- A new request is accepted in T+2 after a two-cycle operation, i.e. back-to-back at one access per 2 cycles. Stores of type SW can issue every cycle.
- MemReq while Busy is ignored. It does not queue and produces no Done.
- Reset asserted during MERGE removes the write combinationally: no partial word is written and Done is not asserted.
- Reset asserted during LOAD discards the load; LoadData reads 0.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 → DmemWrite for one cycle at index 4; Done T+1; LW LoadData = 0xDEADBEEF with Done at T+2.
- Word 0x11223344 at 0x20; SB 0xAA to 0x21, then LW 0x20 → one MERGE write of 0x11AA3344; Busy high exactly one cycle.
- Word 0x80FF7F01 at 0x30:
  - LB 0x30 → 0xFFFFFF80.
  - LBU 0x30 → 0x00000080.
  - LH 0x32 → 0x00007F01.
  - LHU 0x30 → 0x000080FF.
- LH 0x31, SW 0x32 and MemSize = 11 → AddrErr pulse each; DmemWrite stays 0; memory unchanged; no Done.
- SH issued, Reset asserted in the MERGE cycle → DmemWrite low throughout; the word is unchanged on readback; Done, AddrErr and LoadData are 0.
- LB issued, with MemReq held high during T+1 carrying an SW → SW ignored, no write; LB completes normally; a new request is accepted at T+2.
